// File: rtl/video_led_sched.sv
// Frame-synchronous scheduler for the LED on-mask: arbitrates host writes against an
// auto-pattern sequencer and commits a new mask only at the end-of-active-frame strobe.
module video_led_sched #(
  parameter int unsigned C_LED_N     = 18,
  parameter int unsigned C_FRAME_DIV = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ck_ee,
  input  logic               hvcy,
  input  logic               req,
  input  logic [C_LED_N-1:0] req_leds,
  output logic               ack,
  input  logic               auto_en,
  input  logic [1:0]         auto_mode,
  output logic [C_LED_N-1:0] leds_on,
  output logic               upd,
  output logic               pend
);

  localparam int unsigned        CTR_W    = 8;
  localparam logic [CTR_W-1:0]   CTR_LAST = CTR_W'(C_FRAME_DIV - 1);
  localparam logic [C_LED_N-1:0] ONE      = C_LED_N'(1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t             state_q, state_d;
  logic [C_LED_N-1:0] pend_q, pend_d;
  logic [C_LED_N-1:0] auto_q, auto_d;
  logic [C_LED_N-1:0] leds_q, leds_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic               dir_right_q, dir_right_d;
  logic               ack_q, ack_d;
  logic               upd_q, upd_d;
  logic               step;
  logic [C_LED_N-1:0] seed;

  // State register; pulses fall back to 0 on disabled cycles via the comb defaults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      auto_q      <= ONE;
      leds_q      <= '0;
      ctr_q       <= '0;
      dir_right_q <= 1'b0;
      ack_q       <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      auto_q      <= auto_d;
      leds_q      <= leds_d;
      ctr_q       <= ctr_d;
      dir_right_q <= dir_right_d;
      ack_q       <= ack_d;
      upd_q       <= upd_d;
    end
  end

  // Next-state: host capture/commit, frame counter, auto-pattern step
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    auto_d      = auto_q;
    leds_d      = leds_q;
    ctr_d       = ctr_q;
    dir_right_d = dir_right_q;
    ack_d       = 1'b0;
    upd_d       = 1'b0;
    step        = 1'b0;
    seed        = auto_q;

    // Shift-based patterns need a set bit to move
    if (auto_q == '0 && !auto_mode[1]) seed = ONE;

    if (ck_ee) begin
      if (hvcy) ctr_d = (ctr_q == CTR_LAST) ? '0 : ctr_q + CTR_W'(1);

      // A pending commit owns the frame boundary, so steps are only taken from IDLE
      step = hvcy && (ctr_q == CTR_LAST) && auto_en && (state_q == IDLE);

      case (state_q)
        IDLE: begin
          if (req) begin
            pend_d  = req_leds;
            ack_d   = 1'b1;
            state_d = PEND;
          end
        end
        PEND: begin
          if (hvcy) begin
            leds_d  = pend_q;
            upd_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (step) begin
        case (auto_mode)
          2'b00: auto_d = {seed[C_LED_N-2:0], seed[C_LED_N-1]};
          2'b01: begin
            if (!dir_right_q) begin
              if (seed[C_LED_N-1]) begin
                dir_right_d = 1'b1;
                auto_d      = seed >> 1;
              end else begin
                auto_d = seed << 1;
              end
            end else begin
              if (seed[0]) begin
                dir_right_d = 1'b0;
                auto_d      = seed << 1;
              end else begin
                auto_d = seed >> 1;
              end
            end
          end
          2'b10:   auto_d = auto_q + ONE;
          default: auto_d = ~auto_q;
        endcase
        leds_d = auto_d;
        upd_d  = 1'b1;
      end
    end
  end

  assign ack     = ack_q;
  assign upd     = upd_q;
  assign leds_on = leds_q;
  assign pend    = (state_q == PEND);

endmodule

// File: tb/tb_video_led_sched.sv
// Directed bench for video_led_sched with a 2-frame auto step divider.
module tb_video_led_sched;

  localparam int unsigned N = 18;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         ck_ee     = 1'b1;
  logic         hvcy      = 1'b0;
  logic         req       = 1'b0;
  logic         auto_en   = 1'b0;
  logic [1:0]   auto_mode = 2'b00;
  logic [N-1:0] req_leds  = '0;
  logic         ack, upd, pend;
  logic [N-1:0] leds_on;

  int vectors = 0;
  int errors  = 0;
  int nhv     = 0;  // enabled HVCY pulses since reset; odd count before a pulse = step frame

  always #5 clk = ~clk;

  video_led_sched #(.C_LED_N(N), .C_FRAME_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ck_ee     (ck_ee),
    .hvcy      (hvcy),
    .req       (req),
    .req_leds  (req_leds),
    .ack       (ack),
    .auto_en   (auto_en),
    .auto_mode (auto_mode),
    .leds_on   (leds_on),
    .upd       (upd),
    .pend      (pend)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hv_pulse();
    hvcy = 1'b1;
    tick();
    hvcy = 1'b0;
    if (ck_ee) nhv++;
  endtask

  // Run idle frames until the next pulse lands on a step frame, then issue it
  task automatic advance_to_step();
    while (nhv % 2 == 0) begin
      hv_pulse();
      tick();
    end
    hv_pulse();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    vectors++;
    if (leds_on !== '0 || ack !== 1'b0 || upd !== 1'b0 || pend !== 1'b0) begin
      errors++;
      $display("FAIL reset: leds=%h ack=%b upd=%b pend=%b want 0/0/0/0", leds_on, ack, upd, pend);
    end
    rst_n = 1'b1;
    nhv   = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      hv_pulse();
      vectors++;
      if (leds_on !== '0 || upd !== 1'b0) begin
        errors++;
        $display("FAIL idle_frame%0d: leds=%h upd=%b want 00000/0", i, leds_on, upd);
      end
      tick();
    end
  endtask

  task automatic test_host_write();
    tick();
    req = 1'b1; req_leds = 18'h2AAAA;
    tick();
    vectors++;
    if (ack !== 1'b1 || pend !== 1'b1) begin
      errors++;
      $display("FAIL host_ack: ack=%b pend=%b want 1/1", ack, pend);
    end
    req = 1'b0;
    tick();
    vectors++;
    if (ack !== 1'b0 || leds_on !== '0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL host_wait: ack=%b leds=%h upd=%b want 0/00000/0", ack, leds_on, upd);
    end
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h2AAAA || upd !== 1'b1 || pend !== 1'b0) begin
      errors++;
      $display("FAIL host_commit: leds=%h upd=%b pend=%b want 2aaaa/1/0", leds_on, upd, pend);
    end
    tick();
    vectors++;
    if (upd !== 1'b0) begin
      errors++;
      $display("FAIL host_upd_pulse: upd=%b want 0", upd);
    end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; req_leds = 18'h0F0F0;
    tick();
    vectors++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack1: ack=%b want 1", ack);
    end
    req_leds = 18'h15555;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (ack !== 1'b0 || pend !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall%0d: ack=%b pend=%b want 0/1", i, ack, pend);
      end
    end
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h0F0F0 || upd !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_commit1: leds=%h upd=%b ack=%b want 0f0f0/1/0", leds_on, upd, ack);
    end
    tick();
    vectors++;
    if (ack !== 1'b1 || pend !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack2: ack=%b pend=%b want 1/1", ack, pend);
    end
    req = 1'b0;
    tick();
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h15555 || upd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_commit2: leds=%h upd=%b want 15555/1", leds_on, upd);
    end
    tick();
  endtask

  task automatic test_walk();
    logic [N-1:0] exp;
    auto_en = 1'b1; auto_mode = 2'b00;
    for (int k = 0; k < 18; k++) begin
      advance_to_step();
      exp = '0;
      exp[(k + 1) % 18] = 1'b1;
      vectors++;
      if (leds_on !== exp || upd !== 1'b1) begin
        errors++;
        $display("FAIL walk%0d: leds=%h upd=%b want %h/1", k, leds_on, upd, exp);
      end
      tick();
    end
    // Non-step frame: mask holds, no update
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h00001 || upd !== 1'b0) begin
      errors++;
      $display("FAIL walk_hold: leds=%h upd=%b want 00001/0", leds_on, upd);
    end
    tick();
  endtask

  task automatic test_bounce();
    logic [N-1:0] exp;
    int idx = 0;
    bit dir_r = 1'b0;
    auto_mode = 2'b01;
    for (int k = 0; k < 40; k++) begin
      if (!dir_r) begin
        if (idx == N - 1) begin dir_r = 1'b1; idx--; end
        else idx++;
      end else begin
        if (idx == 0) begin dir_r = 1'b0; idx++; end
        else idx--;
      end
      advance_to_step();
      exp = '0;
      exp[idx] = 1'b1;
      vectors++;
      if (leds_on !== exp) begin
        errors++;
        $display("FAIL bounce%0d: leds=%h want %h", k, leds_on, exp);
      end
      tick();
    end
  endtask

  task automatic test_count();
    logic [N-1:0] exp;
    // Bounce left the single bit at index 6 moving left; walk it around to bit 0
    auto_mode = 2'b00;
    for (int k = 0; k < 12; k++) begin
      advance_to_step();
      exp = '0;
      exp[(7 + k) % 18] = 1'b1;
      vectors++;
      if (leds_on !== exp) begin
        errors++;
        $display("FAIL rewalk%0d: leds=%h want %h", k, leds_on, exp);
      end
      tick();
    end
    auto_mode = 2'b11;
    advance_to_step();
    vectors++;
    if (leds_on !== 18'h3FFFE) begin
      errors++;
      $display("FAIL invert: leds=%h want 3fffe", leds_on);
    end
    tick();
    auto_mode = 2'b10;
    advance_to_step();
    vectors++;
    if (leds_on !== 18'h3FFFF) begin
      errors++;
      $display("FAIL count_max: leds=%h want 3ffff", leds_on);
    end
    tick();
    advance_to_step();
    vectors++;
    if (leds_on !== 18'h00000 || upd !== 1'b1) begin
      errors++;
      $display("FAIL count_wrap: leds=%h upd=%b want 00000/1", leds_on, upd);
    end
    tick();
    // Zero auto reg in walk mode reseeds to 1 before rotating
    auto_mode = 2'b00;
    advance_to_step();
    vectors++;
    if (leds_on !== 18'h00002) begin
      errors++;
      $display("FAIL reseed: leds=%h want 00002", leds_on);
    end
    tick();
  endtask

  task automatic test_collision();
    auto_mode = 2'b10;
    while (nhv % 2 == 0) begin
      hv_pulse();
      tick();
    end
    req = 1'b1; req_leds = 18'h12345;
    tick();
    vectors++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL coll_ack: ack=%b want 1", ack);
    end
    req = 1'b0;
    tick();
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h12345 || upd !== 1'b1 || pend !== 1'b0) begin
      errors++;
      $display("FAIL coll_host_wins: leds=%h upd=%b pend=%b want 12345/1/0", leds_on, upd, pend);
    end
    tick();
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h12345 || upd !== 1'b0) begin
      errors++;
      $display("FAIL coll_ctr_wrap: leds=%h upd=%b want 12345/0", leds_on, upd);
    end
    tick();
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h00003 || upd !== 1'b1) begin
      errors++;
      $display("FAIL coll_step_dropped: leds=%h upd=%b want 00003/1", leds_on, upd);
    end
    tick();
    // Capture and HVCY in the same cycle: capture only, commit at the next HVCY
    auto_en = 1'b0;
    req = 1'b1; req_leds = 18'h0AAAA;
    hv_pulse();
    vectors++;
    if (ack !== 1'b1 || upd !== 1'b0 || leds_on !== 18'h00003) begin
      errors++;
      $display("FAIL same_cycle: ack=%b upd=%b leds=%h want 1/0/00003", ack, upd, leds_on);
    end
    req = 1'b0;
    tick();
    hv_pulse();
    vectors++;
    if (leds_on !== 18'h0AAAA || upd !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_commit: leds=%h upd=%b want 0aaaa/1", leds_on, upd);
    end
    tick();
  endtask

  task automatic test_ck_ee();
    ck_ee = 1'b0; auto_en = 1'b1;
    req = 1'b1; req_leds = 18'h11111;
    hvcy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (ack !== 1'b0 || upd !== 1'b0 || pend !== 1'b0 || leds_on !== 18'h0AAAA) begin
        errors++;
        $display("FAIL ck_ee_hold%0d: ack=%b upd=%b pend=%b leds=%h want 0/0/0/0aaaa",
                 i, ack, upd, pend, leds_on);
      end
    end
    hvcy = 1'b0; req = 1'b0; auto_en = 1'b0;
    ck_ee = 1'b1;
    tick();
    vectors++;
    if (pend !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL ck_ee_resume: pend=%b ack=%b want 0/0", pend, ack);
    end
  endtask

  task automatic test_reset_in_pend();
    req = 1'b1; req_leds = 18'h3F000;
    tick();
    vectors++;
    if (pend !== 1'b1) begin
      errors++;
      $display("FAIL rst_pend_setup: pend=%b want 1", pend);
    end
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (leds_on !== '0 || pend !== 1'b0 || ack !== 1'b0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: leds=%h pend=%b ack=%b upd=%b want 00000/0/0/0",
               leds_on, pend, ack, upd);
    end
    #2;
    rst_n = 1'b1;
    nhv   = 0;
    tick();
    hv_pulse();
    vectors++;
    if (leds_on !== '0 || upd !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_stale: leds=%h upd=%b ack=%b want 00000/0/0", leds_on, upd, ack);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_back_to_back();
    test_walk();
    test_bounce();
    test_count();
    test_collision();
    test_ck_ee();
    test_reset_in_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
